wr_repeat_monitor: RTL

//  Synthesizable bus monitor that flags repeated writes to the same address.
//  It keeps a history of the last DEPTH write addresses (optionally with data).

---
 rtl/wr_repeat_monitor_pkg.sv | 14 +
 rtl/wr_repeat_monitor_if.sv | 24 ++
 rtl/wr_repeat_monitor_hist.sv | 46 ++++
 rtl/wr_repeat_monitor.sv | 105 ++++++++++
 4 files changed

// File: rtl/wr_repeat_monitor_pkg.sv
// Shared types and helpers for the write-repeat monitor.
// Holds the match-mode enum and the age-width helper.
package wrmon_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_DATA = 1'b1
  } mode_e;

  function automatic int age_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wr_repeat_monitor_if.sv
// Write-port bundle observed by the repeat monitor.
// The bus master drives it; the monitor only listens.
interface wr_repeat_monitor_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dat;

  modport master (
    output wr_en,
    output addr,
    output dat
  );

  modport slave (
    input wr_en,
    input addr,
    input dat
  );

endinterface

// File: rtl/wr_repeat_monitor_hist.sv
// History shift register of {addr, dat, valid} entries.
// Entry 0 holds the most recent pushed write.
module wr_hist_shift #(
  parameter int DEPTH = 1,
  parameter int W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               flush,
  input  logic [W-1:0]       din,
  output logic [DEPTH*W-1:0] ent_o,
  output logic [DEPTH-1:0]   vld_o
);

  logic [W-1:0]     ent_q [DEPTH];
  logic [W-1:0]     ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    ent_d = ent_q;
    vld_d = flush ? '0 : vld_q;
    if (push) begin
      ent_d[0] = din;
      vld_d[0] = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        ent_d[i] = ent_q[i-1];
        vld_d[i] = flush ? 1'b0 : vld_q[i-1];
      end
    end
  end

  // Payload needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign ent_o[g*W +: W] = ent_q[g];
  end
  assign vld_o = vld_q;

endmodule

// File: rtl/wr_repeat_monitor.sv
// Passive monitor flagging writes that repeat a recent address
// (optionally address and data) within the last DEPTH writes.
module wr_repeat_monitor
  import wrmon_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 8,
  localparam int AGE_W = age_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  wr_repeat_monitor_if.slave  bus,
  input  mode_e               mode,
  input  logic                clr,
  input  logic                flush,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [AGE_W-1:0]    err_age,
  output logic [CNT_W-1:0]    err_count,
  output logic                err_seen
);

  localparam int W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH*W-1:0] ent;
  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   match;
  logic               hit;
  logic [AGE_W-1:0]   age_d;
  logic [CNT_W-1:0]   cnt_base;

  logic              err_q, seen_q, seen_d;
  logic [ADDR_W-1:0] addr_q;
  logic [AGE_W-1:0]  age_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  wr_hist_shift #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .flush (flush),
    .din   ({bus.addr, bus.dat}),
    .ent_o (ent),
    .vld_o (vld)
  );

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld[i]
        && (ent[i*W + DATA_W +: ADDR_W] == bus.addr)
        && (mode == MODE_ADDR
            || ent[i*W +: DATA_W] == bus.dat);
    end
  end

  assign hit = bus.wr_en && (|match);

  // Youngest matching entry wins.
  always_comb begin
    age_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) age_d = AGE_W'(i);
    end
  end

  // Clear applies before a coincident violation.
  always_comb begin
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (hit && cnt_base != CNT_MAX) cnt_d = cnt_base + 1'b1;
    seen_d = (clr ? 1'b0 : seen_q) | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      addr_q <= '0;
      age_q  <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      err_q  <= hit;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      if (hit) begin
        addr_q <= bus.addr;
        age_q  <= age_d;
      end
    end
  end

  assign err       = err_q;
  assign err_addr  = addr_q;
  assign err_age   = age_q;
  assign err_count = cnt_q;
  assign err_seen  = seen_q;

endmodule
